// File: rtl/vec_result_writeback.sv
// Splits a 16x64-bit widened ALU result into low/high 512-bit register-file writes.
// Optional macro SAT_NARROW_EN: single-beat signed saturate-narrow writeback.
module vec_result_writeback #(
  parameter int LANES  = 16,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*LANES*LANE_W-1:0]  in_data,
  input  logic [ADDR_W-1:0]          in_dst_lo,
  input  logic [ADDR_W-1:0]          in_dst_hi,
  input  logic                       in_narrow,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [LANES*LANE_W-1:0]    rf_wdata,
  output logic                       busy,
  output logic                       wb_done
);

  localparam int RES_W  = 2 * LANES * LANE_W;
  localparam int WORD_W = LANES * LANE_W;
  localparam int WIDE_W = 2 * LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RES_W-1:0]    cap_q, cap_d;
  logic [ADDR_W-1:0]   dst_lo_q, dst_lo_d;
  logic [ADDR_W-1:0]   dst_hi_q, dst_hi_d;
  logic                narrow_q, narrow_d;
  logic                transfer;
  logic [WORD_W-1:0]   lo_word;
  logic [WORD_W-1:0]   hi_word;
  logic [WORD_W-1:0]   sat_word;

  // Ready is a function of registered state only, never of in_valid.
  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == WR_HI);
`ifdef SAT_NARROW_EN
    if ((state_q == WR_LO) && narrow_q) begin
      in_ready = 1'b1;
    end
`endif
  end

  assign transfer = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  // Capture registers change only on an accepted transfer.
  assign cap_d    = transfer ? in_data   : cap_q;
  assign dst_lo_d = transfer ? in_dst_lo : dst_lo_q;
  assign dst_hi_d = transfer ? in_dst_hi : dst_hi_q;

`ifdef SAT_NARROW_EN
  assign narrow_d = transfer ? in_narrow : narrow_q;
`else
  logic unused_narrow;
  assign narrow_d      = 1'b0;
  assign unused_narrow = in_narrow ^ narrow_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDE_W-1:0] lane;
      logic              in_range;

      assign lane = cap_q[WIDE_W*gi +: WIDE_W];
      assign lo_word[LANE_W*gi +: LANE_W] = lane[LANE_W-1:0];
      assign hi_word[LANE_W*gi +: LANE_W] = lane[WIDE_W-1:LANE_W];

      // Fits in LANE_W signed bits iff the top LANE_W+1 bits are all equal.
      assign in_range = (&lane[WIDE_W-1:LANE_W-1]) || ~(|lane[WIDE_W-1:LANE_W-1]);

      always_comb begin
        if (in_range) begin
          sat_word[LANE_W*gi +: LANE_W] = lane[LANE_W-1:0];
        end else if (lane[WIDE_W-1]) begin
          sat_word[LANE_W*gi +: LANE_W] = {1'b1, {(LANE_W-1){1'b0}}};
        end else begin
          sat_word[LANE_W*gi +: LANE_W] = {1'b0, {(LANE_W-1){1'b1}}};
        end
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    wb_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        rf_we    = 1'b1;
        rf_waddr = dst_lo_q;
        rf_wdata = lo_word;
        state_d  = WR_HI;
`ifdef SAT_NARROW_EN
        if (narrow_q) begin
          rf_wdata = sat_word;
          wb_done  = 1'b1;
          state_d  = transfer ? WR_LO : IDLE;
        end
`endif
      end
      WR_HI: begin
        rf_we    = 1'b1;
        rf_waddr = dst_hi_q;
        rf_wdata = hi_word;
        wb_done  = 1'b1;
        state_d  = transfer ? WR_LO : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifndef SAT_NARROW_EN
  logic [WORD_W-1:0] unused_sat;
  assign unused_sat = sat_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cap_q    <= '0;
      dst_lo_q <= '0;
      dst_hi_q <= '0;
      narrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      dst_lo_q <= dst_lo_d;
      dst_hi_q <= dst_hi_d;
      narrow_q <= narrow_d;
    end
  end

endmodule

// File: tb/tb_vec_result_writeback.sv
// Directed self-checking bench for vec_result_writeback (default or SAT_NARROW_EN build).
module tb_vec_result_writeback;

  localparam int LANES  = 16;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [2*LANES*LANE_W-1:0] in_data;
  logic [ADDR_W-1:0]         in_dst_lo;
  logic [ADDR_W-1:0]         in_dst_hi;
  logic                      in_narrow;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [LANES*LANE_W-1:0]   rf_wdata;
  logic                      busy;
  logic                      wb_done;

  int checks   = 0;
  int failures = 0;

  vec_result_writeback #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dst_lo (in_dst_lo),
    .in_dst_hi (in_dst_hi),
    .in_narrow (in_narrow),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .wb_done   (wb_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [511:0] data, input logic done, input logic rdy,
                      input logic bsy);
    chk({tag, ".we"},    512'(rf_we),    512'(we));
    chk({tag, ".addr"},  512'(rf_waddr), 512'(addr));
    chk({tag, ".data"},  rf_wdata,       data);
    chk({tag, ".done"},  512'(wb_done),  512'(done));
    chk({tag, ".ready"}, 512'(in_ready), 512'(rdy));
    chk({tag, ".busy"},  512'(busy),     512'(bsy));
    $display("beat %s we=%0b addr=%0d done=%0b ready=%0b busy=%0b w0=%h w1=%h",
             tag, rf_we, rf_waddr, wb_done, in_ready, busy, rf_wdata[31:0], rf_wdata[63:32]);
  endtask

  function automatic logic [31:0] gen_lo(input int k, input int i);
    return 32'hA000_0000 | 32'(k << 8) | 32'(i);
  endfunction
  function automatic logic [31:0] gen_hi(input int k, input int i);
    return 32'h5000_0000 | 32'(k << 12) | 32'(i * 3);
  endfunction

  logic [1023:0] d;
  logic [511:0]  e_lo, e_hi;
  int            done_cnt;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    in_dst_lo = '0; in_dst_hi = '0; in_narrow = 1'b0;

    // 1: reset held two cycles, then released
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    beat("t1_reset", 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0);

    // 2: lane0 = 35, lane1 = -12, dst 1/2
    d = '0;
    d[63:0]   = 64'd35;
    d[127:64] = 64'hFFFF_FFFF_FFFF_FFF4;
    in_data = d; in_dst_lo = 2'd1; in_dst_hi = 2'd2; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    e_lo = '0; e_lo[31:0] = 32'h0000_0023; e_lo[63:32] = 32'hFFFF_FFF4;
    beat("t2_lo", 1'b1, 2'd1, e_lo, 1'b0, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    e_hi = '0; e_hi[31:0] = 32'h0000_0000; e_hi[63:32] = 32'hFFFF_FFFF;
    beat("t2_hi", 1'b1, 2'd2, e_hi, 1'b1, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    beat("t2_idle", 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0);

    // 3: in_valid held high across three distinct results
    done_cnt = 0;
    for (int i = 0; i < LANES; i++) d[64*i +: 64] = {gen_hi(0, i), gen_lo(0, i)};
    in_data = d; in_dst_lo = 2'd0; in_dst_hi = 2'd3; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < LANES; i++) begin
        e_lo[32*i +: 32] = gen_lo(k, i);
        e_hi[32*i +: 32] = gen_hi(k, i);
      end
      beat($sformatf("t3_lo%0d", k), 1'b1, 2'd0, e_lo, 1'b0, 1'b0, 1'b1);
      if (k < 2) begin
        for (int i = 0; i < LANES; i++) d[64*i +: 64] = {gen_hi(k + 1, i), gen_lo(k + 1, i)};
        in_data = d;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      if (wb_done === 1'b1) done_cnt++;
      beat($sformatf("t3_hi%0d", k), 1'b1, 2'd3, e_hi, 1'b1, 1'b1, 1'b1);
    end
    chk("t3_done_count", 512'(done_cnt), 512'd3);
    @(posedge clk); @(negedge clk);
    beat("t3_idle", 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0);

    // 4: same destination for both halves, high word written last
    d = '0;
    d[63:0]    = 64'h1111_2222_3333_4444;
    d[1023:960] = 64'h8765_4321_0FED_CBA9;
    in_data = d; in_dst_lo = 2'd3; in_dst_hi = 2'd3; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    e_lo = '0; e_lo[31:0] = 32'h3333_4444; e_lo[511:480] = 32'h0FED_CBA9;
    e_hi = '0; e_hi[31:0] = 32'h1111_2222; e_hi[511:480] = 32'h8765_4321;
    beat("t4_lo", 1'b1, 2'd3, e_lo, 1'b0, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    beat("t4_hi", 1'b1, 2'd3, e_hi, 1'b1, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);

    // 4b: reset during the low beat cancels the pending high beat
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    beat("t4_lo_pre_rst", 1'b1, 2'd3, e_lo, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    beat("t4_after_rst", 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    beat("t4_still_idle", 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0);

    // 5/6: saturate-narrow stimulus
    d = '0;
    d[63:0]    = 64'h0000_0000_FFFF_FFFE;
    d[127:64]  = 64'h4000_0000_0000_0000;
    d[191:128] = 64'hFFFF_FFFF_0000_0000;
    d[255:192] = 64'h0000_0000_0000_0005;
    in_data = d; in_dst_lo = 2'd2; in_dst_hi = 2'd1; in_narrow = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_narrow = 1'b0;
`ifdef SAT_NARROW_EN
    e_lo = '0;
    e_lo[31:0] = 32'h7FFF_FFFF; e_lo[63:32] = 32'h7FFF_FFFF;
    e_lo[95:64] = 32'h8000_0000; e_lo[127:96] = 32'h0000_0005;
    beat("t5_narrow", 1'b1, 2'd2, e_lo, 1'b1, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    beat("t5_idle", 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0);
`else
    e_lo = '0;
    e_lo[31:0] = 32'hFFFF_FFFE; e_lo[63:32] = 32'h0000_0000;
    e_lo[95:64] = 32'h0000_0000; e_lo[127:96] = 32'h0000_0005;
    e_hi = '0;
    e_hi[31:0] = 32'h0000_0000; e_hi[63:32] = 32'h4000_0000;
    e_hi[95:64] = 32'hFFFF_FFFF; e_hi[127:96] = 32'h0000_0000;
    beat("t6_lo", 1'b1, 2'd2, e_lo, 1'b0, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    beat("t6_hi", 1'b1, 2'd1, e_hi, 1'b1, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    beat("t6_idle", 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
